// File: rtl/ram_port_scheduler.sv
// Arbitrates the single data-RAM port between core and DMA. Core has priority, with a starvation override. Request to x_valid takes 2 cycles plus RAM latency.
// Readies drop outside IDLE or while d_mem_ready=0. RAM_SCHED_TIMEOUT_EN adds a wait-cycle abort that pulses sched_error.
module ram_port_scheduler #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 32,
  parameter int STARVE_LIMIT = 4
`ifdef RAM_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT    = 255
`endif
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      core_read,
  input  logic                      core_write,
  input  logic [DATA_WIDTH/8-1:0]   core_byte_en,
  input  logic [ADDRESS_BITS-1:0]   core_address,
  input  logic [DATA_WIDTH-1:0]     core_wdata,
  output logic [DATA_WIDTH-1:0]     core_rdata,
  output logic [ADDRESS_BITS-1:0]   core_address_out,
  output logic                      core_valid,
  output logic                      core_ready,
  input  logic                      dma_read,
  input  logic                      dma_write,
  input  logic [DATA_WIDTH/8-1:0]   dma_wstrb,
  input  logic [ADDRESS_BITS-1:0]   dma_address,
  input  logic [DATA_WIDTH-1:0]     dma_wdata,
  output logic [DATA_WIDTH-1:0]     dma_rdata,
  output logic                      dma_valid,
  output logic                      dma_ready,
  output logic                      d_mem_read,
  output logic                      d_mem_write,
  output logic [DATA_WIDTH/8-1:0]   d_mem_byte_en,
  output logic [ADDRESS_BITS-1:0]   d_mem_address_in,
  output logic [DATA_WIDTH-1:0]     d_mem_data_in,
  input  logic [DATA_WIDTH-1:0]     d_mem_data_out,
  input  logic [ADDRESS_BITS-1:0]   d_mem_address_out,
  input  logic                      d_mem_valid,
  input  logic                      d_mem_ready,
  output logic                      sched_error
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    IDLE, ISSUE_CORE, ISSUE_DMA, WAIT_CORE, WAIT_DMA, DONE
  } state_t;

  state_t                    state, state_nxt;
  logic [3:0]                starve_cnt, starve_nxt;
  logic                      grant_core, grant_dma;
  logic                      core_req, dma_req;
  logic                      timeout_hit;
  logic                      req_write;
  logic [ADDRESS_BITS-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]     req_wdata;
  logic [DATA_WIDTH/8-1:0]   req_be;

  assign core_req   = core_read | core_write;
  assign dma_req    = dma_read | dma_write;
  assign core_ready = (state == IDLE) & d_mem_ready;
  assign dma_ready  = (state == IDLE) & d_mem_ready;

  // RAM port is driven purely from the latched request; strobes live only in ISSUE.
  assign d_mem_read       = ((state == ISSUE_CORE) || (state == ISSUE_DMA)) && !req_write;
  assign d_mem_write      = ((state == ISSUE_CORE) || (state == ISSUE_DMA)) && req_write;
  assign d_mem_byte_en    = req_be;
  assign d_mem_address_in = req_addr;
  assign d_mem_data_in    = req_wdata;

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    grant_core = 1'b0;
    grant_dma  = 1'b0;
    case (state)
      IDLE: begin
        if (d_mem_ready) begin
          if (dma_req && (!core_req || starve_cnt >= STARVE_LIM)) begin
            grant_dma  = 1'b1;
            starve_nxt = 4'd0;
            state_nxt  = ISSUE_DMA;
          end else if (core_req) begin
            grant_core = 1'b1;
            state_nxt  = ISSUE_CORE;
            if (dma_req && starve_cnt != 4'hf) starve_nxt = starve_cnt + 4'd1;
          end
        end
      end
      ISSUE_CORE: state_nxt = WAIT_CORE;
      ISSUE_DMA:  state_nxt = WAIT_DMA;
      WAIT_CORE, WAIT_DMA: begin
        if (d_mem_valid || timeout_hit) state_nxt = DONE;
      end
      // DONE holds off arbitration while x_valid is out, so a strobe still held that cycle is not re-granted.
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      starve_cnt       <= 4'd0;
      req_write        <= 1'b0;
      req_addr         <= '0;
      req_wdata        <= '0;
      req_be           <= '0;
      core_valid       <= 1'b0;
      core_rdata       <= '0;
      core_address_out <= '0;
      dma_valid        <= 1'b0;
      dma_rdata        <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      core_valid <= 1'b0;
      dma_valid  <= 1'b0;
      if (grant_core) begin
        req_write <= core_write & ~core_read;
        req_addr  <= core_address;
        req_wdata <= core_wdata;
        req_be    <= core_byte_en;
      end else if (grant_dma) begin
        req_write <= dma_write & ~dma_read;
        req_addr  <= dma_address;
        req_wdata <= dma_wdata;
        req_be    <= dma_wstrb;
      end
      if (state == WAIT_CORE && (d_mem_valid || timeout_hit)) begin
        core_valid       <= 1'b1;
        core_rdata       <= d_mem_valid ? d_mem_data_out : '0;
        core_address_out <= d_mem_valid ? d_mem_address_out : req_addr;
      end
      if (state == WAIT_DMA && (d_mem_valid || timeout_hit)) begin
        dma_valid <= 1'b1;
        dma_rdata <= d_mem_valid ? d_mem_data_out : '0;
      end
    end
  end

`ifdef RAM_SCHED_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt;
  logic       err_q;

  assign timeout_hit = ((state == WAIT_CORE) || (state == WAIT_DMA)) && !d_mem_valid &&
                       (wait_cnt == TIMEOUT_LAST);
  assign sched_error = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      err_q <= timeout_hit;
      if ((state == WAIT_CORE) || (state == WAIT_DMA)) wait_cnt <= wait_cnt + 8'd1;
      else wait_cnt <= 8'd0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign sched_error = 1'b0;
`endif

endmodule

// File: tb/tb_ram_port_scheduler.sv
// Directed bench for ram_port_scheduler: 1-cycle RAM model, hand-computed latencies, grant order and reset abort.
module tb_ram_port_scheduler;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        core_read, core_write, dma_read, dma_write;
  logic [3:0]  core_byte_en, dma_wstrb, d_mem_byte_en;
  logic [31:0] core_address, core_wdata, core_rdata, core_address_out;
  logic [31:0] dma_address, dma_wdata, dma_rdata;
  logic        core_valid, core_ready, dma_valid, dma_ready;
  logic        d_mem_read, d_mem_write, d_mem_ready, sched_error;
  logic [31:0] d_mem_address_in, d_mem_data_in, d_mem_data_out, d_mem_address_out;
  wire         d_mem_valid;
  logic        ram_vld = 1'b0, spur_vld, ram_en;
  logic [31:0] ram_rdata;

  int n_checks = 0, n_pass = 0;
  int strobe_cnt = 0, wr_cnt = 0, core_vld_cnt = 0, dma_vld_cnt = 0;
  logic [31:0] strobe_log [0:63];

  always #5 clk = ~clk;

  ram_port_scheduler dut (
    .clk(clk), .reset_n(reset_n),
    .core_read(core_read), .core_write(core_write), .core_byte_en(core_byte_en),
    .core_address(core_address), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .core_address_out(core_address_out), .core_valid(core_valid), .core_ready(core_ready),
    .dma_read(dma_read), .dma_write(dma_write), .dma_wstrb(dma_wstrb),
    .dma_address(dma_address), .dma_wdata(dma_wdata), .dma_rdata(dma_rdata),
    .dma_valid(dma_valid), .dma_ready(dma_ready),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_byte_en(d_mem_byte_en),
    .d_mem_address_in(d_mem_address_in), .d_mem_data_in(d_mem_data_in),
    .d_mem_data_out(d_mem_data_out), .d_mem_address_out(d_mem_address_out),
    .d_mem_valid(d_mem_valid), .d_mem_ready(d_mem_ready), .sched_error(sched_error)
  );

  // RAM answers one cycle after each strobe when ram_en is set.
  assign d_mem_valid    = ram_vld | spur_vld;
  assign d_mem_data_out = ram_rdata;
  always @(posedge clk) begin
    ram_vld           <= ram_en && (d_mem_read || d_mem_write);
    d_mem_address_out <= d_mem_address_in;
    if (d_mem_read || d_mem_write) begin
      strobe_log[strobe_cnt[5:0]] <= d_mem_address_in;
      strobe_cnt <= strobe_cnt + 1;
    end
    if (d_mem_write) wr_cnt <= wr_cnt + 1;
    if (core_valid) core_vld_cnt <= core_vld_cnt + 1;
    if (dma_valid) dma_vld_cnt <= dma_vld_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  int base, cbase, dbase, wbase, n;
  logic [31:0] exp_addr;

  initial begin
    reset_n = 1'b0; spur_vld = 1'b0; ram_en = 1'b1; ram_rdata = 32'h0;
    core_read = 0; core_write = 0; core_byte_en = 4'hf; core_address = 0; core_wdata = 0;
    dma_read = 0; dma_write = 0; dma_wstrb = 0; dma_address = 0; dma_wdata = 0;
    d_mem_ready = 1'b0;
    cycles(3);
    check("rst_core_ready", core_ready, 0);
    check("rst_dma_ready", dma_ready, 0);
    check("rst_strobes", {d_mem_read, d_mem_write}, 0);
    check("rst_valids", {core_valid, dma_valid, sched_error}, 0);
    check("rst_addr", d_mem_address_in, 0);
    reset_n = 1'b1; d_mem_ready = 1'b1;
    cycles(1);
    check("idle_ready", {core_ready, dma_ready}, 2'b11);

    // core read 0x100 -> data 3 cycles after request
    ram_rdata = 32'hDEADBEEF; core_address = 32'h100; core_read = 1'b1;
    cycles(1);
    check("c_rd_strobe", {d_mem_read, d_mem_write}, 2'b10);
    check("c_rd_busy", core_ready, 0);
    cycles(1);
    check("c_rd_early", core_valid, 0);
    cycles(1);
    check("c_rd_valid", core_valid, 1);
    check("c_rd_data", core_rdata, 32'hDEADBEEF);
    check("c_rd_addr", core_address_out, 32'h100);
    core_read = 1'b0;
    cycles(1);
    check("c_rd_pulse", core_valid, 0);
    cycles(2);

    // DMA write with partial strobes
    wbase = wr_cnt; dbase = dma_vld_cnt; cbase = core_vld_cnt;
    dma_write = 1'b1; dma_address = 32'h200; dma_wstrb = 4'b0011; dma_wdata = 32'hCAFEF00D;
    cycles(1);
    check("d_wr_strobe", {d_mem_read, d_mem_write}, 2'b01);
    check("d_wr_be", d_mem_byte_en, 4'b0011);
    check("d_wr_data", d_mem_data_in, 32'hCAFEF00D);
    check("d_wr_addr", d_mem_address_in, 32'h200);
    cycles(2);
    check("d_wr_valid", dma_valid, 1);
    dma_write = 1'b0;
    cycles(4);
    check("d_wr_pulses", wr_cnt - wbase, 1);
    check("d_wr_valids", dma_vld_cnt - dbase, 1);
    check("d_wr_no_core", core_vld_cnt - cbase, 0);

    // read and write together: read wins
    core_read = 1'b1; core_write = 1'b1; core_address = 32'h180;
    cycles(1);
    check("rw_read_wins", {d_mem_read, d_mem_write}, 2'b10);
    cycles(2);
    check("rw_valid", core_valid, 1);
    core_read = 1'b0; core_write = 1'b0;
    cycles(3);

    // continuous contention -> C,C,C,C,D repeating
    base = strobe_cnt;
    core_read = 1'b1; core_address = 32'h100;
    dma_write = 1'b1; dma_address = 32'h200;
    n = 0;
    while (strobe_cnt - base < 10 && n < 200) begin
      cycles(1);
      n++;
    end
    core_read = 1'b0; dma_write = 1'b0;
    check("arb_budget", n < 200, 1);
    for (int i = 0; i < 10; i++) begin
      exp_addr = (i % 5 == 4) ? 32'h200 : 32'h100;
      check($sformatf("arb_grant%0d", i), strobe_log[(base + i) % 64], exp_addr);
    end
    cycles(6);

    // RAM not ready for 10 cycles with both requesting
    d_mem_ready = 1'b0; base = strobe_cnt;
    core_read = 1'b1; dma_read = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      check("stall_ready", {core_ready, dma_ready}, 0);
    end
    check("stall_no_strobe", strobe_cnt - base, 0);
    d_mem_ready = 1'b1;
    cycles(1);
    check("stall_grant", {d_mem_read, d_mem_address_in}, {1'b1, 32'h100});
    dma_read = 1'b0;
    cycles(2);
    check("stall_valid", core_valid, 1);
    core_read = 1'b0;
    cycles(3);

    // reset in WAIT_CORE, then spurious d_mem_valid
    ram_en = 1'b0; cbase = core_vld_cnt; ram_rdata = 32'h12345678;
    core_read = 1'b1; core_address = 32'h140;
    cycles(4);
    reset_n = 1'b0; core_read = 1'b0;
    #1;
    check("abort_strobes", {d_mem_read, d_mem_write, core_valid, dma_valid}, 0);
    cycles(2);
    reset_n = 1'b1;
    cycles(1);
    spur_vld = 1'b1;
    cycles(1);
    spur_vld = 1'b0;
    cycles(3);
    check("abort_no_valid", core_vld_cnt - cbase, 0);
    check("abort_idle", core_ready, 1);
    check("abort_rdata", core_rdata, 0);
    check("abort_addr", d_mem_address_in, 0);

`ifdef RAM_SCHED_TIMEOUT_EN
    // silent RAM: 1 issue cycle + 255 wait cycles, response the cycle after
    core_read = 1'b1; core_address = 32'h300;
    n = 0;
    while (!core_valid && n < 400) begin
      cycles(1);
      n++;
    end
    check("to_latency", n, 257);
    check("to_error", sched_error, 1);
    check("to_rdata", core_rdata, 0);
    core_read = 1'b0;
    cycles(1);
    check("to_error_pulse", sched_error, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
